// File: rtl/lc3b_types.sv
// Shared type package for the LC-3b memory subsystem.
// Holds the line-memory arbiter state encoding. Data widths are module
// parameters because different arbiter instances use different line sizes.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req         - per-channel request vector
//   last_grant  - index of the most recently granted channel
//   grant_valid - high when any channel requests
//   grant_idx   - first requesting channel found when searching upward from
//                 last_grant+1, wrapping modulo NUM_CH
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest one, so the channel
  // closest after last_grant is written last and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_CH);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Multi-channel cache-line memory arbiter.
// Grants one requester at a time (round-robin), latches its operation,
// address and write line, and holds them on the memory side until the
// memory responds. A one-cycle DONE state after each response keeps a
// request that is still held from being granted a second time.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   ch_read/ch_write         - per-channel line read/write requests
//   ch_address/ch_wdata      - per-channel address and write line
//   ch_resp                  - per-channel completion pulse (combinational)
//   ch_rdata                 - read line shared by all channels (= mem_rdata)
//   mem_read/mem_write       - registered memory-side requests
//   mem_address/mem_wdata    - latched memory-side address and write line
//   mem_resp/mem_rdata       - memory completion and read line
module line_mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
  input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic [LINE_W-1:0]              ch_rdata,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [LINE_W-1:0]              mem_wdata,
  input  logic                           mem_resp,
  input  logic [LINE_W-1:0]              mem_rdata
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_t        state;
  logic [IDX_W-1:0]  last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req         (ch_read | ch_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // last_grant doubles as the index of the channel currently being served.
  // Write has priority over read when a channel raises both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_CH - 1);
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_idx;
            mem_write  <= ch_write[grant_idx];
            mem_read   <= ~ch_write[grant_idx];
            addr_q     <= ch_address[grant_idx];
            wdata_q    <= ch_wdata[grant_idx];
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is only meaningful while a transaction is outstanding.
  always_comb begin
    ch_resp = '0;
    if (state == BUSY && mem_resp) ch_resp[last_grant] = 1'b1;
  end

  assign ch_rdata    = mem_rdata;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
module tb_line_mem_arbiter;

  typedef struct {
    int          ch;
    bit          wr;
    logic [15:0] addr;
    logic [127:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Two-channel instance, default widths
  logic [1:0]         a_ch_read = '0, a_ch_write = '0, a_ch_resp;
  logic [1:0][15:0]   a_ch_address = '0;
  logic [1:0][127:0]  a_ch_wdata = '0;
  logic [127:0]       a_ch_rdata, a_mem_wdata;
  logic [127:0]       a_mem_rdata = '0;
  logic               a_mem_read, a_mem_write;
  logic               a_mem_resp = 1'b0;
  logic [15:0]        a_mem_address;

  // Four-channel instance, narrow line
  logic [3:0]         b_ch_read = '0, b_ch_write = '0, b_ch_resp;
  logic [3:0][15:0]   b_ch_address = '0;
  logic [3:0][31:0]   b_ch_wdata = '0;
  logic [31:0]        b_ch_rdata, b_mem_wdata;
  logic [31:0]        b_mem_rdata = 32'h1234_5678;
  logic               b_mem_read, b_mem_write;
  logic               b_mem_resp = 1'b0;
  logic [15:0]        b_mem_address;

  int total = 0;
  int bad = 0;
  txn_t sbq[$];
  logic [127:0] mem_model [logic [15:0]];

  localparam logic [127:0] A5_LINE = {16{8'hA5}};
  localparam logic [127:0] RD_LINE = {4{32'hDEAD_BEEF}};

  line_mem_arbiter u_dut2 (
    .clk(clk), .rst(rst),
    .ch_read(a_ch_read), .ch_write(a_ch_write),
    .ch_address(a_ch_address), .ch_wdata(a_ch_wdata),
    .ch_resp(a_ch_resp), .ch_rdata(a_ch_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_address(a_mem_address), .mem_wdata(a_mem_wdata),
    .mem_resp(a_mem_resp), .mem_rdata(a_mem_rdata)
  );

  line_mem_arbiter #(.NUM_CH(4), .LINE_W(32), .ADDR_W(16)) u_dut4 (
    .clk(clk), .rst(rst),
    .ch_read(b_ch_read), .ch_write(b_ch_write),
    .ch_address(b_ch_address), .ch_wdata(b_ch_wdata),
    .ch_resp(b_ch_resp), .ch_rdata(b_ch_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
    .mem_resp(b_mem_resp), .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_mem_resp = 1'b1;
    cyc(); #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read: got %b want 0", a_mem_read); end
    total++; if (a_mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write: got %b want 0", a_mem_write); end
    total++; if (a_ch_resp !== 2'b00) begin bad++; $display("FAIL rst_ch_resp: got %b want 00", a_ch_resp); end
    total++; if (a_mem_address !== 16'h0) begin bad++; $display("FAIL rst_mem_address: got %h want 0", a_mem_address); end
    total++; if (a_mem_wdata !== 128'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", a_mem_wdata); end
    total++; if (b_mem_read !== 1'b0 || b_ch_resp !== 4'b0) begin bad++; $display("FAIL rst_b: mem_read=%b ch_resp=%b want 0/0000", b_mem_read, b_ch_resp); end
    total++; if (b_mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_b_wdata: got %h want 0", b_mem_wdata); end
    cyc(); rst = 1'b0; #1;
    // mem_resp in IDLE must not produce a completion or start anything
    total++; if (a_ch_resp !== 2'b00) begin bad++; $display("FAIL idle_resp_ignored: got %b want 00", a_ch_resp); end
    cyc(); a_mem_resp = 1'b0; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL idle_no_read: got %b want 0", a_mem_read); end
  endtask

  task automatic test_single_read();
    txn_t exp;
    cyc(); a_ch_read = 2'b01; a_ch_address[0] = 16'h1000;
    sbq.push_back('{0, 1'b0, 16'h1000, 128'h0}); #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL sr_c0: mem_read=%b want 0", a_mem_read); end
    cyc(); #1;
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== 16'h1000) begin bad++; $display("FAIL sr_c1: mem_read=%b addr=%h want 1/1000", a_mem_read, a_mem_address); end
    cyc(); #1;
    total++; if (a_mem_read !== 1'b1) begin bad++; $display("FAIL sr_c2: mem_read=%b want 1", a_mem_read); end
    cyc(); a_mem_resp = 1'b1; a_mem_rdata = RD_LINE; #1;
    exp = sbq.pop_front();
    total++; if (a_ch_resp !== 2'(1 << exp.ch)) begin bad++; $display("FAIL sr_ch_resp: got %b want %b", a_ch_resp, 2'(1 << exp.ch)); end
    total++; if (a_mem_read !== 1'b1 || a_mem_write !== exp.wr || a_mem_address !== exp.addr) begin bad++; $display("FAIL sr_c3_req: rd=%b wr=%b addr=%h want 1/%b/%h", a_mem_read, a_mem_write, a_mem_address, exp.wr, exp.addr); end
    total++; if (a_ch_rdata !== RD_LINE) begin bad++; $display("FAIL sr_rdata: got %h want %h", a_ch_rdata, RD_LINE); end
    cyc(); a_mem_resp = 1'b0; a_ch_read = 2'b00; #1;
    total++; if (a_mem_read !== 1'b0 || a_ch_resp !== 2'b00) begin bad++; $display("FAIL sr_done: mem_read=%b ch_resp=%b want 0/00", a_mem_read, a_ch_resp); end
    cyc();
  endtask

  task automatic test_two_reads();
    txn_t exp;
    cyc(); rst = 1'b1; cyc(); rst = 1'b0;
    cyc(); a_ch_read = 2'b11; a_ch_address[0] = 16'h1100; a_ch_address[1] = 16'h1200;
    sbq.push_back('{0, 1'b0, 16'h1100, 128'h0});
    sbq.push_back('{1, 1'b0, 16'h1200, 128'h0});
    cyc(); #1;
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== 16'h1100) begin bad++; $display("FAIL tr_first: rd=%b addr=%h want 1/1100", a_mem_read, a_mem_address); end
    cyc(); a_mem_resp = 1'b1; #1;
    exp = sbq.pop_front();
    total++; if (a_ch_resp !== 2'(1 << exp.ch) || a_mem_address !== exp.addr) begin bad++; $display("FAIL tr_resp0: resp=%b addr=%h want %b/%h", a_ch_resp, a_mem_address, 2'(1 << exp.ch), exp.addr); end
    cyc(); a_mem_resp = 1'b0; a_ch_read = 2'b10; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL tr_done: mem_read=%b want 0", a_mem_read); end
    cyc(); #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL tr_idle: mem_read=%b want 0", a_mem_read); end
    cyc(); a_mem_resp = 1'b1; #1;
    exp = sbq.pop_front();
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== exp.addr) begin bad++; $display("FAIL tr_second: rd=%b addr=%h want 1/%h", a_mem_read, a_mem_address, exp.addr); end
    total++; if (a_ch_resp !== 2'(1 << exp.ch)) begin bad++; $display("FAIL tr_resp1: got %b want %b", a_ch_resp, 2'(1 << exp.ch)); end
    cyc(); a_mem_resp = 1'b0; a_ch_read = 2'b00; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL tr_end: mem_read=%b want 0", a_mem_read); end
    cyc();
  endtask

  task automatic test_write_hold();
    txn_t exp;
    logic [127:0] stored;
    cyc(); a_ch_write = 2'b10; a_ch_read = 2'b10;
    a_ch_address[1] = 16'h2040; a_ch_wdata[1] = A5_LINE;
    sbq.push_back('{1, 1'b1, 16'h2040, A5_LINE});
    cyc(); a_ch_address[1] = 16'h3000; a_ch_wdata[1] = 128'h0; #1;
    total++; if (a_mem_write !== 1'b1 || a_mem_read !== 1'b0) begin bad++; $display("FAIL wh_op: wr=%b rd=%b want 1/0", a_mem_write, a_mem_read); end
    total++; if (a_mem_address !== 16'h2040) begin bad++; $display("FAIL wh_addr_c1: got %h want 2040", a_mem_address); end
    cyc(); #1;
    total++; if (a_mem_address !== 16'h2040 || a_mem_wdata !== A5_LINE) begin bad++; $display("FAIL wh_c2: addr=%h wdata=%h want 2040/%h", a_mem_address, a_mem_wdata, A5_LINE); end
    cyc(); a_mem_resp = 1'b1; #1;
    exp = sbq.pop_front();
    if (a_mem_write === 1'b1) mem_model[a_mem_address] = a_mem_wdata;
    total++; if (a_ch_resp !== 2'(1 << exp.ch)) begin bad++; $display("FAIL wh_resp: got %b want %b", a_ch_resp, 2'(1 << exp.ch)); end
    total++; if (a_mem_address !== exp.addr || a_mem_wdata !== exp.data) begin bad++; $display("FAIL wh_at_resp: addr=%h wdata=%h want %h/%h", a_mem_address, a_mem_wdata, exp.addr, exp.data); end
    cyc(); a_mem_resp = 1'b0; a_ch_write = 2'b00; a_ch_read = 2'b00; #1;
    stored = mem_model.exists(16'h2040) ? mem_model[16'h2040] : 'x;
    total++; if (stored !== A5_LINE) begin bad++; $display("FAIL wh_mem_store: got %h want %h", stored, A5_LINE); end
    total++; if (a_mem_write !== 1'b0) begin bad++; $display("FAIL wh_done: mem_write=%b want 0", a_mem_write); end
    cyc();
  endtask

  task automatic test_reset_busy();
    txn_t exp;
    cyc(); a_ch_read = 2'b10; a_ch_address[1] = 16'h4000;
    cyc(); #1;
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== 16'h4000) begin bad++; $display("FAIL rb_busy: rd=%b addr=%h want 1/4000", a_mem_read, a_mem_address); end
    cyc(); rst = 1'b1; a_mem_resp = 1'b1; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL rb_read_cleared: got %b want 0", a_mem_read); end
    total++; if (a_ch_resp !== 2'b00) begin bad++; $display("FAIL rb_no_resp: got %b want 00", a_ch_resp); end
    total++; if (a_mem_address !== 16'h0) begin bad++; $display("FAIL rb_addr_cleared: got %h want 0", a_mem_address); end
    cyc(); rst = 1'b0; a_mem_resp = 1'b0; a_ch_read = 2'b11; a_ch_address[0] = 16'h5000;
    sbq.push_back('{0, 1'b0, 16'h5000, 128'h0});
    cyc(); a_mem_resp = 1'b1; #1;
    exp = sbq.pop_front();
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== exp.addr) begin bad++; $display("FAIL rb_regrant: rd=%b addr=%h want 1/%h", a_mem_read, a_mem_address, exp.addr); end
    total++; if (a_ch_resp !== 2'(1 << exp.ch)) begin bad++; $display("FAIL rb_resp: got %b want %b", a_ch_resp, 2'(1 << exp.ch)); end
    cyc(); a_mem_resp = 1'b0; a_ch_read = 2'b00;
    cyc();
  endtask

  task automatic test_hold_past_resp();
    txn_t exp;
    cyc(); a_ch_read = 2'b01; a_ch_address[0] = 16'h6000;
    sbq.push_back('{0, 1'b0, 16'h6000, 128'h0});
    cyc(); a_mem_resp = 1'b1; #1;
    exp = sbq.pop_front();
    total++; if (a_mem_read !== 1'b1 || a_mem_address !== exp.addr || a_ch_resp !== 2'(1 << exp.ch)) begin bad++; $display("FAIL hp_resp: rd=%b addr=%h resp=%b want 1/%h/%b", a_mem_read, a_mem_address, a_ch_resp, exp.addr, 2'(1 << exp.ch)); end
    cyc(); a_mem_resp = 1'b0; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL hp_done: mem_read=%b want 0", a_mem_read); end
    cyc(); a_ch_read = 2'b00; #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL hp_idle: mem_read=%b want 0", a_mem_read); end
    cyc(); #1;
    total++; if (a_mem_read !== 1'b0) begin bad++; $display("FAIL hp_no_regrant: mem_read=%b want 0", a_mem_read); end
    cyc();
  endtask

  task automatic test_round_robin();
    txn_t exp;
    int cnt [4];
    bit seen;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    cyc();
    b_ch_read = 4'hF;
    for (int c = 0; c < 4; c++) b_ch_address[c] = 16'((c + 1) * 16'h0100);
    sbq.push_back('{0, 1'b0, 16'h0100, 128'h0});
    sbq.push_back('{1, 1'b0, 16'h0200, 128'h0});
    sbq.push_back('{2, 1'b0, 16'h0300, 128'h0});
    sbq.push_back('{3, 1'b0, 16'h0400, 128'h0});
    sbq.push_back('{0, 1'b0, 16'h0100, 128'h0});
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        cyc(); b_mem_resp = 1'b0; #1;
        seen = b_mem_read;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rr_timeout: grant %0d never issued", g); break; end
      exp = sbq.pop_front();
      b_mem_resp = 1'b1; #1;
      total++; if (b_ch_resp !== 4'(1 << exp.ch) || b_mem_address !== exp.addr) begin bad++; $display("FAIL rr_grant%0d: resp=%b addr=%h want %b/%h", g, b_ch_resp, b_mem_address, 4'(1 << exp.ch), exp.addr); end
      total++; if (b_mem_write !== 1'b0 || b_ch_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rr_side%0d: wr=%b rdata=%h want 0/12345678", g, b_mem_write, b_ch_rdata); end
      for (int c = 0; c < 4; c++) if (b_ch_resp[c] === 1'b1) cnt[c]++;
    end
    cyc(); b_mem_resp = 1'b0; b_ch_read = 4'h0;
    for (int c = 0; c < 4; c++) begin
      total++; if (cnt[c] < 1) begin bad++; $display("FAIL rr_starved: ch%0d served %0d times want >=1", c, cnt[c]); end
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_two_reads();
    test_write_hold();
    test_reset_busy();
    test_hold_past_resp();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
LINE_MEM_ARBITER -- requirements
Module: line_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of requester channels (legal range 2..8).
REQ-002 The block SHALL have parameter LINE_W, default 128, cache-line data width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port ch_read, input, NUM_CH: per-channel line read request.
REQ-007 The block SHALL have port ch_write, input, NUM_CH: per-channel line write request.
REQ-008 The block SHALL have port ch_address, input, NUM_CH x ADDR_W: per-channel line address.
REQ-009 The block SHALL have port ch_wdata, input, NUM_CH x LINE_W: per-channel write line.
REQ-010 The block SHALL have port ch_resp, output, NUM_CH: per-channel completion pulse.
REQ-011 The block SHALL have port ch_rdata, output, LINE_W: read line, shared by all channels.
REQ-012 The block SHALL have ports mem_read and mem_write, output, 1 each: memory-side requests.
REQ-013 The block SHALL have ports mem_address (ADDR_W) and mem_wdata (LINE_W), output: memory-side address and write line.
REQ-014 The block SHALL have ports mem_resp (1) and mem_rdata (LINE_W), input: memory-side completion and read line.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-016 IDLE: if any channel has read|write high, the block SHALL grant one channel, latch its op, address and wdata, and enter BUSY on that edge.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_CH; last_grant updates on each grant.
REQ-018 A channel with both read and write high SHALL be serviced as a write.
REQ-019 BUSY: mem_read or mem_write SHALL be driven from the latched op, with mem_address and mem_wdata from latched registers, held stable until mem_resp.
REQ-020 Requester signals changing during BUSY SHALL NOT affect the memory-side outputs.
REQ-021 mem_resp in BUSY SHALL assert ch_resp[grant] combinationally in the same cycle; all other ch_resp bits SHALL be 0.
REQ-022 ch_rdata SHALL equal mem_rdata combinationally at all times.
REQ-023 On mem_resp in BUSY the FSM SHALL enter DONE; mem_read and mem_write SHALL be 0 in DONE.
REQ-024 DONE SHALL last exactly one cycle, grant nothing, and return to IDLE, so a request still held after its resp is never re-granted.
REQ-025 mem_resp in IDLE or DONE SHALL be ignored.
REQ-026 Latency: request sampled at edge t gives mem_* asserted from cycle t+1; mem_resp at cycle r gives IDLE at r+2.
REQ-027 An ungranted channel SHALL wait at most NUM_CH-1 grants of other channels before its own grant.

Reset
REQ-028 rst high SHALL immediately force state IDLE, last_grant NUM_CH-1 (so channel 0 wins first), mem_read 0, mem_write 0, ch_resp 0, and latched address/wdata 0.
REQ-029 Reset during BUSY SHALL abandon the transaction; no ch_resp SHALL be produced for it.

Structure
REQ-030 The arb_state_t enum (IDLE/BUSY/DONE) SHALL live in the shared lc3b_types package; LINE_W and ADDR_W stay module parameters.
REQ-031 Round-robin selection SHALL be a separate combinational sub-module rr_arbiter(req, last_grant -> grant_valid, grant_idx).

Verification
REQ-032 The bench SHALL cover: ch0 read 0x1000 alone, memory resp after 3 cycles -> mem_read cycles 1-3, ch_resp=2'b01 in cycle 3, ch_rdata=mem_rdata.
REQ-033 The bench SHALL cover: ch0 and ch1 both read at once after reset -> ch0 granted first, ch1 granted 2 cycles after ch0's resp.
REQ-034 The bench SHALL cover: NUM_CH=4 with all channels requesting continuously -> grant order 0,1,2,3,0; no channel starved.
REQ-035 The bench SHALL cover: ch1 write 0x2040 with wdata 128'hA5.., ch1 changes address mid-BUSY -> mem_address stays 0x2040 and the memory stores A5.. there.
REQ-036 The bench SHALL cover: rst pulse while BUSY -> mem_read 0 before the next edge, no ch_resp, next grant to ch0.
REQ-037 The bench SHALL cover: ch0 holds read one cycle past resp -> no second mem_read for that request, because of the DONE state.
